// File: rtl/trace_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trace_request_sequencer
// Brief    : Replays decoded trace entries (address + read/write bit) to the
//            cache under test as single-outstanding valid/ready requests,
//            tallies reads, writes, hits and misses, and flags completion.
//            Optional macro TRACE_STALL_CNT_EN adds a saturating stall_count
//            output (cycles spent waiting on req_ready or resp_valid).
// Revision : 1.0 - initial release
// ============================================================================
module trace_request_sequencer #(
  parameter int NUM_INSTR = 524,
  parameter int ADDR_W    = 20,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address       [NUM_INSTR],
  input  logic              operation_bit [NUM_INSTR],
  input  logic              start,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_write,
  input  logic              resp_valid,
  input  logic              resp_hit,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  read_count,
  output logic [CNT_W-1:0]  write_count,
  output logic [CNT_W-1:0]  hit_count,
`ifdef TRACE_STALL_CNT_EN
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  stall_count
`else
  output logic [CNT_W-1:0]  miss_count
`endif
);

  localparam int IDX_W = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INSTR - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] index_inc;
  logic             launch;    // start accepted in IDLE
  logic             accept;    // request handshake this cycle
  logic             complete;  // response for the outstanding request
  logic             last;      // current entry is the final one

  assign index_inc = index + 1'b1;
  assign last      = (index == LAST_IDX);

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (resp_valid) begin
          complete   = 1'b1;
          state_next = last ? DONE : ISSUE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered request outputs, run flags, index and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index       <= '0;
      req_valid   <= 1'b0;
      req_addr    <= '0;
      req_write   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      read_count  <= '0;
      write_count <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      if (launch) begin
        index       <= '0;
        req_valid   <= 1'b1;
        req_addr    <= address[0];
        req_write   <= operation_bit[0];
        busy        <= 1'b1;
        done        <= 1'b0;
        read_count  <= '0;
        write_count <= '0;
        hit_count   <= '0;
        miss_count  <= '0;
      end
      if (accept) begin
        req_valid <= 1'b0;
        if (req_write) begin
          write_count <= sat_inc(write_count);
        end else begin
          read_count <= sat_inc(read_count);
        end
      end
      if (complete) begin
        if (resp_hit) begin
          hit_count <= sat_inc(hit_count);
        end else begin
          miss_count <= sat_inc(miss_count);
        end
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          index     <= index_inc;
          req_valid <= 1'b1;
          req_addr  <= address[index_inc];
          req_write <= operation_bit[index_inc];
        end
      end
    end
  end

`ifdef TRACE_STALL_CNT_EN
  // Cycles lost to cache backpressure or response latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (launch) begin
      stall_count <= '0;
    end else if (((state == ISSUE) && !req_ready) ||
                 ((state == WAIT_RESP) && !resp_valid)) begin
      stall_count <= sat_inc(stall_count);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_trace_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_request_sequencer
// Brief    : Self-checking bench for trace_request_sequencer; a 4-entry
//            instance for functional scenarios and a 6-entry, 2-bit-counter
//            instance for saturation. Expected values come from a reference
//            model counting the trace contents directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_request_sequencer;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int CW = 16;
  localparam int N2 = 6;
  localparam int CW2 = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] address [N];
  logic          operation_bit [N];
  logic          start = 1'b0, req_ready = 1'b0, resp_valid = 1'b0, resp_hit = 1'b0;
  logic          req_valid, req_write, busy, done;
  logic [AW-1:0] req_addr;
  logic [CW-1:0] read_count, write_count, hit_count, miss_count;
  logic          hits [N];

  logic [AW-1:0] address2 [N2];
  logic          op2 [N2];
  logic          start2 = 1'b0, req_ready2 = 1'b0, resp_valid2 = 1'b0, resp_hit2 = 1'b0;
  logic          req_valid2, req_write2, busy2, done2;
  logic [AW-1:0] req_addr2;
  logic [CW2-1:0] read2, write2, hit2, miss2;

`ifdef TRACE_STALL_CNT_EN
  logic [CW-1:0]  stall_count;
  logic [CW2-1:0] stall2;
`endif

  int passed = 0;
  int total  = 0;
  int exp_stall;
  int basic_stall;

  always #5 clk = ~clk;

  trace_request_sequencer #(.NUM_INSTR(N), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .address(address), .operation_bit(operation_bit),
    .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .busy(busy), .done(done), .read_count(read_count),
    .write_count(write_count), .hit_count(hit_count),
`ifdef TRACE_STALL_CNT_EN
    .miss_count(miss_count), .stall_count(stall_count)
`else
    .miss_count(miss_count)
`endif
  );

  trace_request_sequencer #(.NUM_INSTR(N2), .ADDR_W(AW), .CNT_W(CW2)) dut_sat (
    .clk(clk), .rst(rst), .address(address2), .operation_bit(op2),
    .start(start2), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_addr(req_addr2), .req_write(req_write2), .resp_valid(resp_valid2),
    .resp_hit(resp_hit2), .busy(busy2), .done(done2), .read_count(read2),
    .write_count(write2), .hit_count(hit2),
`ifdef TRACE_STALL_CNT_EN
    .miss_count(miss2), .stall_count(stall2)
`else
    .miss_count(miss2)
`endif
  );

  // Reference model: statistics are plain counts over the trace, clipped.
  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic int model_reads();
    int n = 0;
    for (int i = 0; i < N; i++) if (!operation_bit[i]) n++;
    return sat(n, CW);
  endfunction

  function automatic int model_hits();
    int n = 0;
    for (int i = 0; i < N; i++) if (hits[i]) n++;
    return sat(n, CW);
  endfunction

  task automatic load_basic();
    address[0] = 20'h00010; operation_bit[0] = 1'b0; hits[0] = 1'b0;
    address[1] = 20'h00020; operation_bit[1] = 1'b1; hits[1] = 1'b0;
    address[2] = 20'h00010; operation_bit[2] = 1'b0; hits[2] = 1'b1;
    address[3] = 20'h00030; operation_bit[3] = 1'b1; hits[3] = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      address[i]       = AW'($urandom);
      operation_bit[i] = 1'($urandom);
      hits[i]          = 1'($urandom);
    end
  endtask

  // Serve one entry as the cache: optional backpressure, strays, or abort.
  task automatic serve(input int i, input int stall, input bit stray,
                       input bit abort, input bit rnd, output bit stop);
    int wt = 0;
    int d;
    int done_before;
    stop = 1'b0;
    while (!req_valid && wt < 20) begin @(negedge clk); wt++; end
    total++;
    if (req_valid !== 1'b1) begin
      $display("FAIL req_timeout entry=%0d req_valid=%b want 1", i, req_valid);
      stop = 1'b1;
      return;
    end else passed++;
    done_before = int'(hit_count) + int'(miss_count);
    total++;
    if (req_addr !== address[i] || req_write !== operation_bit[i])
      $display("FAIL req_order entry=%0d addr=%h wr=%b want addr=%h wr=%b",
               i, req_addr, req_write, address[i], operation_bit[i]);
    else passed++;
    for (int k = 0; k < stall; k++) begin
      if (stray && k == 0) begin resp_valid = 1'b1; resp_hit = 1'b1; start = 1'b1; end
      @(negedge clk);
      resp_valid = 1'b0; start = 1'b0;
      total++;
      if (req_valid !== 1'b1 || req_addr !== address[i] || req_write !== operation_bit[i] ||
          int'(hit_count) + int'(miss_count) != done_before)
        $display("FAIL stall_hold entry=%0d v=%b addr=%h wr=%b resp=%0d want v=1 addr=%h wr=%b resp=%0d",
                 i, req_valid, req_addr, req_write, int'(hit_count) + int'(miss_count),
                 address[i], operation_bit[i], done_before);
      else passed++;
    end
    req_ready  = 1'b1;
    resp_valid = stray;
    resp_hit   = 1'b1;
    @(negedge clk);
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    total++;
    if (req_valid !== 1'b0 || int'(read_count) + int'(write_count) != i + 1 ||
        int'(hit_count) + int'(miss_count) != done_before)
      $display("FAIL accept entry=%0d v=%b issued=%0d resp=%0d want v=0 issued=%0d resp=%0d",
               i, req_valid, int'(read_count) + int'(write_count),
               int'(hit_count) + int'(miss_count), i + 1, done_before);
    else passed++;
    if (abort) begin
      #2 rst = 1'b1;
      #1;
      total++;
      if ({req_valid, req_write, busy, done} !== 4'b0 || req_addr !== '0 ||
          read_count !== '0 || write_count !== '0 || hit_count !== '0 || miss_count !== '0)
        $display("FAIL async_reset v=%b wr=%b busy=%b done=%b addr=%h r=%0d w=%0d h=%0d m=%0d want all 0",
                 req_valid, req_write, busy, done, req_addr, read_count, write_count,
                 hit_count, miss_count);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      resp_valid = 1'b1; resp_hit = 1'b1;
      @(negedge clk);
      resp_valid = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || req_valid !== 1'b0 || hit_count !== '0 || miss_count !== '0)
        $display("FAIL post_reset_resp busy=%b v=%b h=%0d m=%0d want 0 0 0 0",
                 busy, req_valid, hit_count, miss_count);
      else passed++;
      stop = 1'b1;
      return;
    end
    d = rnd ? int'($urandom_range(2, 0)) : 0;
    repeat (d) @(negedge clk);
    resp_valid = 1'b1;
    resp_hit   = hits[i];
    @(negedge clk);
    resp_valid = 1'b0;
    exp_stall += stall + d;
  endtask

  task automatic run_trace(input int stall_entry, input int stall_len, input bit stray,
                           input int abort_entry, input bit rnd);
    bit stop;
    int exp_r, exp_h;
    exp_stall = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || read_count !== '0 || write_count !== '0 ||
        hit_count !== '0 || miss_count !== '0)
      $display("FAIL run_start busy=%b done=%b r=%0d w=%0d h=%0d m=%0d want busy=1 others 0",
               busy, done, read_count, write_count, hit_count, miss_count);
    else passed++;
    for (int i = 0; i < N; i++) begin
      serve(i, (i == stall_entry) ? stall_len : 0, stray && (i == stall_entry),
            i == abort_entry, rnd, stop);
      if (stop) return;
    end
    exp_r = model_reads();
    exp_h = model_hits();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || req_valid !== 1'b0 ||
        read_count !== CW'(exp_r) || write_count !== CW'(sat(N - exp_r, CW)) ||
        hit_count !== CW'(exp_h) || miss_count !== CW'(sat(N - exp_h, CW)))
      $display("FAIL run_end done=%b busy=%b r=%0d w=%0d h=%0d m=%0d want done=1 busy=0 r=%0d w=%0d h=%0d m=%0d",
               done, busy, read_count, write_count, hit_count, miss_count,
               exp_r, N - exp_r, exp_h, N - exp_h);
    else passed++;
`ifdef TRACE_STALL_CNT_EN
    total++;
    if (stall_count !== CW'(exp_stall))
      $display("FAIL stall_count got=%0d want=%0d", stall_count, exp_stall);
    else passed++;
`endif
    @(negedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL done_sticky done=%b busy=%b want 1 0", done, busy);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({req_valid, req_write, busy, done} !== 4'b0 || req_addr !== '0 ||
        read_count !== '0 || write_count !== '0 || hit_count !== '0 || miss_count !== '0)
      $display("FAIL reset_state v=%b wr=%b busy=%b done=%b addr=%h want all 0",
               req_valid, req_write, busy, done, req_addr);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray_idle();
    resp_valid = 1'b1; resp_hit = 1'b1;
    repeat (2) @(negedge clk);
    resp_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || req_valid !== 1'b0 || hit_count !== '0 || miss_count !== '0)
      $display("FAIL stray_idle busy=%b v=%b h=%0d m=%0d want 0 0 0 0",
               busy, req_valid, hit_count, miss_count);
    else passed++;
  endtask

  task automatic test_basic();
    load_basic();
    run_trace(-1, 0, 1'b0, -1, 1'b0);
    basic_stall = exp_stall;
  endtask

  task automatic test_backpressure();
    load_basic();
    run_trace(1, 5, 1'b0, -1, 1'b0);
    total++;
    if (exp_stall != basic_stall + 5)
      $display("FAIL backpressure_model stall=%0d want=%0d", exp_stall, basic_stall + 5);
    else passed++;
  endtask

  task automatic test_stray_and_retrigger();
    load_random();
    run_trace(2, 3, 1'b1, -1, 1'b1);
  endtask

  task automatic test_reset_midrun();
    load_basic();
    run_trace(-1, 0, 1'b0, 2, 1'b0);
    run_trace(-1, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      load_random();
      run_trace(int'($urandom_range(N - 1, 0)), int'($urandom_range(3, 0)), 1'($urandom),
                -1, 1'b1);
    end
  endtask

  task automatic test_saturation();
    int wt = 0;
    for (int i = 0; i < N2; i++) begin address2[i] = AW'(i * 16); op2[i] = 1'b0; end
    req_ready2 = 1'b1; resp_valid2 = 1'b1; resp_hit2 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    while (!done2 && wt < 60) begin @(negedge clk); wt++; end
    total++;
    if (done2 !== 1'b1 || read2 !== CW2'(sat(N2, CW2)) || hit2 !== CW2'(sat(N2, CW2)) ||
        write2 !== '0 || miss2 !== '0)
      $display("FAIL saturation done=%b r=%0d w=%0d h=%0d m=%0d want done=1 r=%0d w=0 h=%0d m=0",
               done2, read2, write2, hit2, miss2, sat(N2, CW2), sat(N2, CW2));
    else passed++;
    resp_valid2 = 1'b0; req_ready2 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N2; i++) begin address2[i] = '0; op2[i] = 1'b0; end
    load_basic();
    test_reset();
    test_stray_idle();
    test_basic();
    test_backpressure();
    test_stray_and_retrigger();
    test_reset_midrun();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_request_sequencer.md
Name: trace_request_sequencer

Overview:
- Consumes the decoded trace arrays from the trace assembler: 20-bit addresses plus one operation bit per entry.
- Replays the entries in order as single-outstanding requests to the cache under test, using a valid/ready request channel and a valid response channel.
- Tallies reads, writes, hits and misses, then flags completion.
- Sits between the trace assembler and the cache model in the simulation top.

Parameters:
- NUM_INSTR, 524, number of trace entries replayed; legal range is 1 or more.
- ADDR_W, 20, address width in bits.
- CNT_W, 16, width of every statistics counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- address  input  ADDR_W x NUM_INSTR (unpacked array)  trace addresses; stable for the whole run.
- operation_bit  input  1 x NUM_INSTR (unpacked array)  per entry: 1 = write, 0 = read.
- start  input  1  one-cycle pulse; begins a run from entry 0.
- req_valid  output  1  request present.
- req_ready  input  1  cache accepts the request.
- req_addr  output  ADDR_W  request address.
- req_write  output  1  1 = write, 0 = read.
- resp_valid  input  1  cache completes the outstanding request.
- resp_hit  input  1  completion was a hit; qualified by resp_valid.
- busy  output  1  a run is in progress.
- done  output  1  sticky end-of-run flag.
- read_count  output  CNT_W  reads issued.
- write_count  output  CNT_W  writes issued.
- hit_count  output  CNT_W  responses with resp_hit=1.
- miss_count  output  CNT_W  responses with resp_hit=0.

Behaviour:
- Reset, applied asynchronously:
  - State returns to IDLE and the index clears to 0.
  - req_valid, req_addr, req_write, busy, done and all counters go to 0.
  - Reset mid-run abandons the run; any later resp_valid is ignored.
- IDLE:
  - start=1 clears all counters and done, sets index to 0 and moves to ISSUE on the next edge.
  - busy=1 from that edge onward.
- ISSUE:
  - req_valid=1, req_addr=address[index], req_write=operation_bit[index], all driven from registers.
  - The outputs stay stable while req_ready=0.
  - On req_valid & req_ready: read_count or write_count increments by 1, then move to WAIT_RESP.
- WAIT_RESP:
  - req_valid=0.
  - On resp_valid: hit_count or miss_count increments by 1.
  - If index == NUM_INSTR-1, move to DONE. Otherwise increment index and return to ISSUE.
- Request spacing: minimum 2 cycles between successive request acceptances (issue, then response, then next issue).
- DONE:
  - busy=0 and done=1; done stays high until the next start or reset.
  - Go to IDLE on the next edge. done is unaffected by that transition.
- Ignored inputs:
  - start while busy is ignored.
  - resp_valid outside WAIT_RESP is ignored, including resp_valid in the same cycle as the request handshake.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Invariants at done:
  - read_count + write_count = NUM_INSTR.
  - hit_count + miss_count = NUM_INSTR.
- Index width is $clog2(NUM_INSTR), minimum 1.

Optional Feature:
- Macro: TRACE_STALL_CNT_EN.
- Defined:
  - Adds output stall_count, width CNT_W, reset 0 and cleared on start.
  - Increments every cycle in ISSUE with req_ready=0, and every cycle in WAIT_RESP with resp_valid=0.
  - Saturates like the other counters.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Basic run: NUM_INSTR=4, ops {0,1,0,1}, addresses 0x00010/0x00020/0x00010/0x00030. req_ready=1, responses 1 cycle after acceptance with hits {0,0,1,0}.
  -> Four requests issued in order. read_count=2, write_count=2, hit_count=1, miss_count=3. done=1, busy=0.
- Backpressure: hold req_ready=0 for 5 cycles on entry 1.
  -> req_addr and req_write stay constant and req_valid stays high throughout. With TRACE_STALL_CNT_EN defined, stall_count rises by 5 more than in the basic run.
- Stray responses: resp_valid pulses in IDLE, in ISSUE, and in the same cycle as a handshake.
  -> No counter changes and no state advance.
- Reset mid-run: assert rst while in WAIT_RESP for entry 2, then pulse start.
  -> All outputs are 0 right after rst. The new run restarts at entry 0 and counts match the basic run.
- Re-trigger: start pulsed while busy.
  -> Ignored. After done, a second start clears done and the counters and replays the full trace.
- Saturation: CNT_W=2, NUM_INSTR=6, all reads, all hits.
  -> read_count=3 and hit_count=3 (saturated). done=1 after the 6th response.
